// File: rtl/decoder_stage_pkg.sv
// Shared decode constants for the ID stage: field widths, opcodes, team funct codes
// and the packed main-control bundle.
`ifndef DECODER_STAGE_PKG_SV
`define DECODER_STAGE_PKG_SV
`define OPCODE_WIDTH 6
`define FUNCT_WIDTH 6

package decoder_stage_pkg;

    localparam logic [`OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [`OPCODE_WIDTH-1:0] OP_SLTI  = 6'h01;
    localparam logic [`OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [`OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
    localparam logic [`OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [`OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
    localparam logic [`OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
    localparam logic [`OPCODE_WIDTH-1:0] OP_XORI  = 6'h0E;
    localparam logic [`OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [`OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;

    localparam logic [`FUNCT_WIDTH-1:0] FN_ADD = 6'h20;
    localparam logic [`FUNCT_WIDTH-1:0] FN_SUB = 6'h21;
    localparam logic [`FUNCT_WIDTH-1:0] FN_AND = 6'h22;
    localparam logic [`FUNCT_WIDTH-1:0] FN_OR  = 6'h23;
    localparam logic [`FUNCT_WIDTH-1:0] FN_XOR = 6'h24;

    typedef struct packed {
        logic reg_dst;
        logic reg_wr;
        logic alu_src;
        logic branch;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage
`endif

// File: rtl/decoder_stage_register_file.sv
// 2^AWIDTH x DWIDTH register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear. Register 0 is hardwired to zero.
module decoder_stage_register_file #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic              ds_clk,
    input  logic              ds_rst,
    input  logic [AWIDTH-1:0] rs_addr,
    input  logic [AWIDTH-1:0] rt_addr,
    output logic [DWIDTH-1:0] rs_data,
    output logic [DWIDTH-1:0] rt_data,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] regs_reg [DEPTH];

    always_ff @(posedge ds_clk or posedge ds_rst) begin
        if (ds_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    // No write-to-read bypass: a value written on an edge is seen only after it.
    assign rs_data = (rs_addr == '0) ? '0 : regs_reg[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : regs_reg[rt_addr];

endmodule

// File: rtl/decoder_stage.sv
// MIPS instruction-decode stage: field split, main control decode, register-file
// read/write-back, and the registered ID/EX boundary.
module decoder_stage
    import decoder_stage_pkg::*;
#(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 32,
    parameter int IWIDTH    = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic                     ds_clk,
    input  logic                     ds_rst,
    input  logic                     ds_i_ce,
    input  logic [IWIDTH-1:0]        ds_i_instr,
    input  logic [DWIDTH-1:0]        ds_i_data_rd,
    output logic [`OPCODE_WIDTH-1:0] ds_o_opcode,
    output logic [`FUNCT_WIDTH-1:0]  ds_o_funct,
    output logic [DWIDTH-1:0]        ds_o_data_rs,
    output logic [DWIDTH-1:0]        ds_o_data_rt,
    output logic [IMM_WIDTH-1:0]     ds_o_imm,
    output logic                     ds_o_ce,
    output logic                     ds_o_branch,
    output logic                     ds_o_alu_src,
    output logic                     ds_o_memread,
    output logic                     ds_o_memwrite,
    output logic                     ds_o_memtoreg,
    output logic                     ds_o_reg_dst,
    output logic                     ds_o_reg_wr
);

    logic [`OPCODE_WIDTH-1:0] opcode;
    logic [`FUNCT_WIDTH-1:0]  funct;
    logic [AWIDTH-1:0]        rs_addr;
    logic [AWIDTH-1:0]        rt_addr;
    logic [AWIDTH-1:0]        rd_addr;
    logic [IMM_WIDTH-1:0]     imm;

    assign opcode  = ds_i_instr[31:26];
    assign rs_addr = ds_i_instr[25:21];
    assign rt_addr = ds_i_instr[20:16];
    assign rd_addr = ds_i_instr[15:11];
    assign imm     = ds_i_instr[IMM_WIDTH-1:0];
    assign funct   = ds_i_instr[5:0];

    ctrl_t ctrl_next;

    always_comb begin
        ctrl_next = CTRL_NONE;
        case (opcode)
            OP_RTYPE: begin
                ctrl_next.reg_dst = 1'b1;
                ctrl_next.reg_wr  = 1'b1;
            end
            OP_SLTI, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_next.reg_wr  = 1'b1;
                ctrl_next.alu_src = 1'b1;
            end
            OP_LW: begin
                ctrl_next.reg_wr   = 1'b1;
                ctrl_next.alu_src  = 1'b1;
                ctrl_next.memread  = 1'b1;
                ctrl_next.memtoreg = 1'b1;
            end
            OP_SW: begin
                ctrl_next.alu_src  = 1'b1;
                ctrl_next.memwrite = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_next.branch = 1'b1;
            end
            default: ctrl_next = CTRL_NONE;
        endcase
    end

    logic [DWIDTH-1:0] rs_data;
    logic [DWIDTH-1:0] rt_data;
    logic              rf_wr_en;
    logic [AWIDTH-1:0] rf_wr_addr;

    assign rf_wr_en   = ds_i_ce & ctrl_next.reg_wr;
    assign rf_wr_addr = ctrl_next.reg_dst ? rd_addr : rt_addr;

    decoder_stage_register_file #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_register_file (
        .ds_clk  (ds_clk),
        .ds_rst  (ds_rst),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (rf_wr_en),
        .wr_addr (rf_wr_addr),
        .wr_data (ds_i_data_rd)
    );

    logic [`OPCODE_WIDTH-1:0] opcode_reg;
    logic [`FUNCT_WIDTH-1:0]  funct_reg;
    logic [DWIDTH-1:0]        data_rs_reg;
    logic [DWIDTH-1:0]        data_rt_reg;
    logic [IMM_WIDTH-1:0]     imm_reg;
    logic                     ce_reg;
    logic                     branch_reg;
    logic                     alu_src_reg;
    logic                     memread_reg;
    logic                     memwrite_reg;
    logic                     memtoreg_reg;
    logic                     d_r_o_reg_dst;
    logic                     d_r_o_reg_wr;

    // ID/EX boundary: valid always follows ds_i_ce, payload only loads on a valid cycle.
    always_ff @(posedge ds_clk or posedge ds_rst) begin
        if (ds_rst) begin
            opcode_reg    <= '0;
            funct_reg     <= '0;
            data_rs_reg   <= '0;
            data_rt_reg   <= '0;
            imm_reg       <= '0;
            ce_reg        <= 1'b0;
            branch_reg    <= 1'b0;
            alu_src_reg   <= 1'b0;
            memread_reg   <= 1'b0;
            memwrite_reg  <= 1'b0;
            memtoreg_reg  <= 1'b0;
            d_r_o_reg_dst <= 1'b0;
            d_r_o_reg_wr  <= 1'b0;
        end else begin
            ce_reg <= ds_i_ce;
            if (ds_i_ce) begin
                opcode_reg    <= opcode;
                funct_reg     <= funct;
                data_rs_reg   <= rs_data;
                data_rt_reg   <= rt_data;
                imm_reg       <= imm;
                branch_reg    <= ctrl_next.branch;
                alu_src_reg   <= ctrl_next.alu_src;
                memread_reg   <= ctrl_next.memread;
                memwrite_reg  <= ctrl_next.memwrite;
                memtoreg_reg  <= ctrl_next.memtoreg;
                d_r_o_reg_dst <= ctrl_next.reg_dst;
                d_r_o_reg_wr  <= ctrl_next.reg_wr;
            end
        end
    end

    assign ds_o_opcode   = opcode_reg;
    assign ds_o_funct    = funct_reg;
    assign ds_o_data_rs  = data_rs_reg;
    assign ds_o_data_rt  = data_rt_reg;
    assign ds_o_imm      = imm_reg;
    assign ds_o_ce       = ce_reg;
    assign ds_o_branch   = branch_reg;
    assign ds_o_alu_src  = alu_src_reg;
    assign ds_o_memread  = memread_reg;
    assign ds_o_memwrite = memwrite_reg;
    assign ds_o_memtoreg = memtoreg_reg;
    assign ds_o_reg_dst  = d_r_o_reg_dst;
    assign ds_o_reg_wr   = d_r_o_reg_wr;

endmodule

// File: tb/tb_decoder_stage.sv
// Self-checking bench for decoder_stage: directed plan followed by randomized traffic,
// compared against a table-driven architectural model of the register file and controls.
module tb_decoder_stage;

    logic        ds_clk = 1'b0;
    logic        ds_rst = 1'b1;
    logic        ds_i_ce = 1'b0;
    logic [31:0] ds_i_instr = '0;
    logic [31:0] ds_i_data_rd = '0;
    logic [5:0]  ds_o_opcode;
    logic [5:0]  ds_o_funct;
    logic [31:0] ds_o_data_rs;
    logic [31:0] ds_o_data_rt;
    logic [15:0] ds_o_imm;
    logic        ds_o_ce, ds_o_branch, ds_o_alu_src, ds_o_memread;
    logic        ds_o_memwrite, ds_o_memtoreg, ds_o_reg_dst, ds_o_reg_wr;

    decoder_stage dut (
        .ds_clk        (ds_clk),
        .ds_rst        (ds_rst),
        .ds_i_ce       (ds_i_ce),
        .ds_i_instr    (ds_i_instr),
        .ds_i_data_rd  (ds_i_data_rd),
        .ds_o_opcode   (ds_o_opcode),
        .ds_o_funct    (ds_o_funct),
        .ds_o_data_rs  (ds_o_data_rs),
        .ds_o_data_rt  (ds_o_data_rt),
        .ds_o_imm      (ds_o_imm),
        .ds_o_ce       (ds_o_ce),
        .ds_o_branch   (ds_o_branch),
        .ds_o_alu_src  (ds_o_alu_src),
        .ds_o_memread  (ds_o_memread),
        .ds_o_memwrite (ds_o_memwrite),
        .ds_o_memtoreg (ds_o_memtoreg),
        .ds_o_reg_dst  (ds_o_reg_dst),
        .ds_o_reg_wr   (ds_o_reg_wr)
    );

    always #5 ds_clk = ~ds_clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Architectural model state and expected ID/EX contents.
    logic [31:0] mregs [32];
    logic [5:0]  e_opcode, e_funct;
    logic [31:0] e_rs, e_rt;
    logic [15:0] e_imm;
    logic        e_ce;
    logic [6:0]  e_ctrl;  // {reg_dst, reg_wr, alu_src, branch, memread, memwrite, memtoreg}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [6:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:                         return 7'b1100000;
            6'h01, 6'h08, 6'h0C, 6'h0D, 6'h0E: return 7'b0110000;
            6'h23:                         return 7'b0110101;
            6'h2B:                         return 7'b0010010;
            6'h04, 6'h05:                  return 7'b0001000;
            default:                       return 7'b0000000;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        e_opcode = '0; e_funct = '0; e_rs = '0; e_rt = '0; e_imm = '0;
        e_ce = 1'b0; e_ctrl = '0;
    endtask

    task automatic check_outputs(input string tag);
        check($sformatf("%s.opcode", tag), {26'd0, ds_o_opcode}, {26'd0, e_opcode});
        check($sformatf("%s.funct", tag), {26'd0, ds_o_funct}, {26'd0, e_funct});
        check($sformatf("%s.data_rs", tag), ds_o_data_rs, e_rs);
        check($sformatf("%s.data_rt", tag), ds_o_data_rt, e_rt);
        check($sformatf("%s.imm", tag), {16'd0, ds_o_imm}, {16'd0, e_imm});
        check($sformatf("%s.ce", tag), {31'd0, ds_o_ce}, {31'd0, e_ce});
        check($sformatf("%s.ctrl", tag),
              {25'd0, ds_o_reg_dst, ds_o_reg_wr, ds_o_alu_src, ds_o_branch,
               ds_o_memread, ds_o_memwrite, ds_o_memtoreg},
              {25'd0, e_ctrl});
    endtask

    // One clock of traffic: predict, clock, apply model write-back, compare.
    task automatic step(input string tag, input logic ce, input logic [31:0] instr,
                        input logic [31:0] wd);
        logic [6:0] c;
        logic [4:0] dst;
        ds_i_ce      = ce;
        ds_i_instr   = instr;
        ds_i_data_rd = wd;
        c    = ref_ctrl(instr[31:26]);
        e_ce = ce;
        if (ce) begin
            e_opcode = instr[31:26];
            e_funct  = instr[5:0];
            e_rs     = ref_read(instr[25:21]);
            e_rt     = ref_read(instr[20:16]);
            e_imm    = instr[15:0];
            e_ctrl   = c;
        end
        @(posedge ds_clk);
        #1;
        if (ce && c[5]) begin
            dst = c[6] ? instr[15:11] : instr[20:16];
            if (dst != 5'd0) mregs[dst] = wd;
        end
        check_outputs(tag);
        $display("txn %-6s ce=%0b instr=0x%08h wd=0x%08h -> rs=0x%08h rt=0x%08h ctrl=%07b",
                 tag, ce, instr, wd, ds_o_data_rs, ds_o_data_rt,
                 {ds_o_reg_dst, ds_o_reg_wr, ds_o_alu_src, ds_o_branch,
                  ds_o_memread, ds_o_memwrite, ds_o_memtoreg});
    endtask

    // Async reset between edges: outputs must clear before any clock edge.
    task automatic mid_reset(input string tag);
        #2;
        ds_rst = 1'b1;
        #1;
        model_clear();
        check_outputs(tag);
        check($sformatf("%s.d_r_o_reg_dst", tag), {31'd0, dut.d_r_o_reg_dst}, 32'd0);
        check($sformatf("%s.d_r_o_reg_wr", tag), {31'd0, dut.d_r_o_reg_wr}, 32'd0);
        #1;
        ds_rst = 1'b0;
        $display("txn %-6s async reset pulse", tag);
    endtask

    logic [5:0] op_pool [12] = '{6'h00, 6'h00, 6'h01, 6'h08, 6'h0C, 6'h0D,
                                 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    logic [5:0] fn_pool [5]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24};

    initial begin
        logic [31:0] r, instr;
        logic [5:0]  op;
        model_clear();

        // Reset held for two cycles.
        ds_rst = 1'b1;
        repeat (2) @(posedge ds_clk);
        #1;
        check_outputs("reset");
        check("reset.d_r_o_reg_dst", {31'd0, dut.d_r_o_reg_dst}, 32'd0);
        check("reset.d_r_o_reg_wr", {31'd0, dut.d_r_o_reg_wr}, 32'd0);
        ds_rst = 1'b0;

        // Directed plan.
        step("add",   1'b1, 32'h00430820, 32'd55);
        step("slti",  1'b1, 32'h0424000A, 32'd77);
        check("slti.rs_is_55", ds_o_data_rs, 32'd55);
        step("lw",    1'b1, 32'h8C220004, 32'h0000_1234);
        step("sw",    1'b1, 32'hAC220004, 32'hDEAD_BEEF);
        step("rd_r2", 1'b1, 32'h00221820, 32'd9);   // r2 must hold the LW value, not the SW data
        step("beq",   1'b1, 32'h10220003, 32'hFFFF_FFFF);
        step("inval", 1'b1, 32'hFC22FFFF, 32'hFFFF_FFFF);
        step("ce_lo", 1'b0, 32'h00430820, 32'd99);  // would write r1 if enabled
        step("r0rd",  1'b1, 32'h00010820, 32'd1);   // reads r0 and r1 (r1 still 55)
        step("wr_r0", 1'b1, 32'h20000005, 32'd42);  // ADDI to r0 is dropped
        step("rd_r0", 1'b1, 32'h00000000, 32'd0);
        mid_reset("arst");
        step("post",  1'b1, 32'h00221820, 32'd3);   // regfile wiped: rs/rt read 0

        // Randomized traffic; small register window raises read-after-write hits.
        for (int n = 0; n < 400; n++) begin
            r  = $urandom();
            op = op_pool[$urandom_range(0, 11)];
            if (($urandom_range(0, 9)) == 0) op = 6'(r[31:26]);
            instr = {op, r[25:0]};
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            instr[15:11] = 5'($urandom_range(0, 7));
            if (op == 6'h00) instr[5:0] = fn_pool[$urandom_range(0, 4)];
            step("rand", ($urandom_range(0, 4) != 0), instr, $urandom());
            if ($urandom_range(0, 99) == 0) mid_reset("rarst");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
